// File: rtl/logic_gates_checker_if.sv
// Stimulus/response and status bundle between the LogicGates self-test
// checker (master) and whatever surrounds it (slave): the unit under test
// supplies the eight gate responses, the host supplies start and reads status.
interface logic_gates_checker_if;
  logic       start;
  logic       A;
  logic       B;
  logic       Buf;
  logic       Not;
  logic       And;
  logic       Nand;
  logic       Or;
  logic       Nor;
  logic       Xor;
  logic       Xnor;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [1:0] fail_vec;
  logic [7:0] fail_mask;

  modport master (
    input  start, Buf, Not, And, Nand, Or, Nor, Xor, Xnor,
    output A, B, busy, done, pass, err_count, fail_vec, fail_mask
  );

  modport slave (
    output start, Buf, Not, And, Nand, Or, Nor, Xor, Xnor,
    input  A, B, busy, done, pass, err_count, fail_vec, fail_mask
  );
endinterface

// File: rtl/logic_gates_checker.sv
// Exhaustive self-test sequencer for the two-input LogicGates unit.
// Steps {A,B} through 00,01,10,11, holds each for DWELL cycles, samples
// all eight gate outputs on one CHECK cycle and accumulates the result.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start, vector parked at 00
//   DRIVE | vector applied, dwell counter running down to 0
//   CHECK | compare responses against truth table, advance or finish
//   FIN   | one-cycle done pulse, pass/err_count final
//
// DWELL legal range is 1..255 (the dwell counter is 8 bits).
module logic_gates_checker #(
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  logic_gates_checker_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  localparam logic [7:0] CNT_LOAD = 8'(DWELL - 1);

  logic [1:0] state;
  logic [1:0] vec;
  logic [7:0] cnt;
  logic [2:0] err_count;
  logic [1:0] fail_vec;
  logic [7:0] fail_mask;
  logic       pass;

  logic [7:0] actual;
  logic [7:0] expected;
  logic [7:0] mismatch;
  logic [2:0] err_next;

  // Responses and the truth table share the {Buf,Not,And,Nand,Or,Nor,Xor,Xnor} order.
  assign actual   = {bus.Buf, bus.Not, bus.And, bus.Nand,
                     bus.Or,  bus.Nor, bus.Xor, bus.Xnor};
  assign expected = {vec[1], ~vec[1], &vec, ~(&vec), |vec, ~(|vec), ^vec, ~(^vec)};
  assign mismatch = actual ^ expected;
  // At most four failing vectors, so a 3-bit count never wraps.
  assign err_next = err_count + 3'(|mismatch);

  // Sequencer and result registers; pass is resolved on entry to FIN so
  // it is already valid alongside the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= 2'd0;
      cnt       <= 8'd0;
      err_count <= 3'd0;
      fail_vec  <= 2'd0;
      fail_mask <= 8'd0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vec <= 2'd0;
          if (bus.start) begin
            state     <= DRIVE;
            cnt       <= CNT_LOAD;
            err_count <= 3'd0;
            fail_vec  <= 2'd0;
            fail_mask <= 8'd0;
            pass      <= 1'b0;
          end
        end
        DRIVE: begin
          if (cnt == 8'd0) begin
            state <= CHECK;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        CHECK: begin
          if (|mismatch) begin
            err_count <= err_next;
            if (err_count == 3'd0) begin
              fail_vec  <= vec;
              fail_mask <= mismatch;
            end
          end
          if (vec == 2'd3) begin
            state <= FIN;
            pass  <= (err_next == 3'd0);
          end else begin
            vec   <= vec + 2'd1;
            cnt   <= CNT_LOAD;
            state <= DRIVE;
          end
        end
        FIN: begin
          state <= IDLE;
          vec   <= 2'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.A         = vec[1];
  assign bus.B         = vec[0];
  assign bus.busy      = (state == DRIVE) || (state == CHECK);
  assign bus.done      = (state == FIN);
  assign bus.pass      = pass;
  assign bus.err_count = err_count;
  assign bus.fail_vec  = fail_vec;
  assign bus.fail_mask = fail_mask;

endmodule
